cell_draw_scheduler: RTL and testbench
======================================

Name: cell_draw_scheduler

Overview:
- Sequences the display-update pass for the 16x12 snake grid.
- Rasters the x/y scan coordinates that the object encoder reads, and compares each cell's current object code against a frame buffer holding what is on screen.
- For every cell that differs, issues one draw command to the LCD command engine and waits for cmd_done.
- The first pass after reset, and any pass requested via full_redraw, redraws every cell.

Parameters:
GRID_W, 16, grid columns; x counts 0..GRID_W-1
GRID_H, 12, grid rows; y counts 0..GRID_H-1
CODE_W, 3, object code width

Ports:
clk  in  1  system clock, rising edge
nrst  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse from game tick; begins a pass
obj_code_in  in  CODE_W  object code of cell (x,y), combinational from game logic
full_redraw  in  1  pulse; forces next pass to redraw all cells
cmd_done  in  1  one-cycle pulse from LCD engine; current draw finished
x  out  4  scan column
y  out  4  scan row
draw_req  out  1  draw command valid, held until cmd_done
draw_x  out  4  column of pending draw
draw_y  out  4  row of pending draw
draw_code  out  CODE_W  object code to draw
busy  out  1  high in any state except IDLE
frame_done  out  1  one-cycle pulse at end of pass
init_cycle  out  1  high from reset until the first pass completes

Behaviour:
- Reset is asynchronous, active-low, on nrst; clock is clk.
- Reset values: state=IDLE; x, y, draw_x, draw_y, draw_code=0; draw_req, busy, frame_done=0; init_cycle=1; force_pending=1; every frame buffer entry=0.
- Frame buffer: GRID_W*GRID_H entries of CODE_W bits, indexed y*GRID_W+x. It is written only on an accepted cmd_done, at index (draw_x, draw_y), with value draw_code.
- States: IDLE, SCAN, WAIT, DONE.
- IDLE:
  - x=y=0.
  - On start: force_active<=force_pending, force_pending<=0, go to SCAN.
- SCAN, one cell per cycle:
  - Draw needed when obj_code_in != buffer[x,y], or when force_active=1.
  - If draw needed: latch draw_x<=x, draw_y<=y, draw_code<=obj_code_in; set draw_req<=1; go to WAIT. x and y hold.
  - Otherwise: advance.
- WAIT:
  - x, y, draw_x, draw_y and draw_code are frozen; draw_req stays 1.
  - On cmd_done: write the buffer, set draw_req<=0, advance.
  - No timeout; WAIT holds indefinitely until cmd_done.
- Advance:
  - x<GRID_W-1: x+1.
  - Otherwise x<=0 and y+1.
  - After cell (GRID_W-1, GRID_H-1): go to DONE, with x=y=0.
- DONE, one cycle:
  - frame_done=1, init_cycle<=0, force_active<=0.
  - Next state IDLE.
- Latency: start sampled at edge 0 puts SCAN at cell (0,0) in cycle 1.
  - A pass with no diffs scans (15,11) in cycle 192 and pulses frame_done in cycle 193.
  - Each draw adds a WAIT occupancy of at least 1 cycle; cmd_done may be asserted combinationally on the first WAIT cycle.
- Boundary conditions:
  - start while busy: ignored; it is not queued.
  - cmd_done outside WAIT: ignored; no buffer write.
  - full_redraw at any time sets force_pending. It never affects the pass in progress; it applies to the next start.
  - full_redraw in the same cycle IDLE accepts start: applies to this pass (force_active=1).
  - start and cmd_done in the same cycle in WAIT: cmd_done handled, start ignored.
  - Last cell drawn: cmd_done in WAIT for (15,11) goes directly to DONE.
  - nrst mid-pass, including in WAIT: draw_req drops immediately (async), buffer is cleared, init_cycle=1, so the next pass is a full redraw.
  - Outputs x and y are registered. obj_code_in is sampled in the same cycle the coordinates are presented.

Test Plan:
1. Reset; obj_code_in=0 everywhere (border code 1 at x=0/15 or y=0/11); start; cmd_done 1 cycle after each draw_req -> 192 draws in raster order (0,0),(1,0)..(15,11), draw_code matching the cell, one frame_done pulse, init_cycle 1 then 0 after DONE.
2. Second start with identical obj_code_in -> draw_req never asserts; frame_done exactly 193 cycles after start; busy high for cycles 1..193.
3. Change only cell (4,4) to code 2 (head) and (7,4) to code 3 (apple); start -> exactly two draws: (4,4,2) then (7,4,3). Repeat the pass -> zero draws.
4. Delay cmd_done 5 cycles -> draw_req, draw_x and draw_y stable for all 5 cycles and x/y frozen. cmd_done pulse while IDLE -> no buffer change (next pass still diffs). start pulse during busy -> no second pass.
5. full_redraw pulse mid-pass -> current pass draws only the diffs; next start draws all 192 cells. full_redraw coincident with start -> that pass draws all 192.
6. nrst low during WAIT at cell (7,4) -> draw_req=0 and busy=0 within the same cycle, init_cycle=1; next start redraws all 192 cells from (0,0).

Source files
------------

// File: rtl/cell_draw_scheduler.sv
// Display-update sequencer for the snake grid: rasters scan coordinates, diffs each
// cell against the on-screen frame buffer and issues one draw command per changed cell.
module cell_draw_scheduler #(
  parameter int GRID_W = 16,
  parameter int GRID_H = 12,
  parameter int CODE_W = 3
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              start,
  input  logic [CODE_W-1:0] obj_code_in,
  input  logic              full_redraw,
  input  logic              cmd_done,
  output logic [3:0]        x,
  output logic [3:0]        y,
  output logic              draw_req,
  output logic [3:0]        draw_x,
  output logic [3:0]        draw_y,
  output logic [CODE_W-1:0] draw_code,
  output logic              busy,
  output logic              frame_done,
  output logic              init_cycle,
  output logic [1:0]        state_dbg
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SCAN = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam int         CELLS  = GRID_W * GRID_H;
  localparam int         IDX_W  = $clog2(CELLS);
  localparam logic [3:0] X_LAST = 4'(GRID_W - 1);
  localparam logic [3:0] Y_LAST = 4'(GRID_H - 1);

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic              force_pending;
  logic              force_active;
  logic [CODE_W-1:0] fb [CELLS];

  logic [IDX_W-1:0]  scan_idx;
  logic [IDX_W-1:0]  draw_idx;
  logic              accept_start;
  logic              accept_done;
  logic              draw_needed;
  logic              advance;
  logic              last_cell;

  assign scan_idx = IDX_W'(y) * IDX_W'(GRID_W) + IDX_W'(x);
  assign draw_idx = IDX_W'(draw_y) * IDX_W'(GRID_W) + IDX_W'(draw_x);

  // Handshake: draw_req is a valid that stays high, with draw_x/draw_y/draw_code
  // frozen, until the engine returns a one-cycle cmd_done; cmd_done is only
  // honoured while a draw is outstanding (WAIT), otherwise it is dropped.
  assign accept_start = (state == S_IDLE) && start;
  assign accept_done  = (state == S_WAIT) && cmd_done;
  assign draw_needed  = (state == S_SCAN) &&
                        ((obj_code_in != fb[scan_idx]) || force_active);
  assign advance      = ((state == S_SCAN) && !draw_needed) || accept_done;
  assign last_cell    = (x == X_LAST) && (y == Y_LAST);

  assign busy       = (state != S_IDLE);
  assign frame_done = (state == S_DONE);
  assign state_dbg  = state;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_SCAN;
      end
      S_SCAN: begin
        if (draw_needed)    state_nxt = S_WAIT;
        else if (last_cell) state_nxt = S_DONE;
      end
      S_WAIT: begin
        if (cmd_done) state_nxt = last_cell ? S_DONE : S_SCAN;
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Raster counter: holds while a draw is outstanding, wraps to (0,0) after the last cell.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      x <= 4'd0;
      y <= 4'd0;
    end else if (state == S_IDLE) begin
      x <= 4'd0;
      y <= 4'd0;
    end else if (advance) begin
      if (last_cell) begin
        x <= 4'd0;
        y <= 4'd0;
      end else if (x != X_LAST) begin
        x <= x + 4'd1;
      end else begin
        x <= 4'd0;
        y <= y + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      draw_req  <= 1'b0;
      draw_x    <= 4'd0;
      draw_y    <= 4'd0;
      draw_code <= '0;
    end else if (draw_needed) begin
      draw_req  <= 1'b1;
      draw_x    <= x;
      draw_y    <= y;
      draw_code <= obj_code_in;
    end else if (accept_done) begin
      draw_req  <= 1'b0;
    end
  end

  // A redraw request arriving with the accepted start applies to that pass;
  // at any other time it waits for the next start.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      force_pending <= 1'b1;
      force_active  <= 1'b0;
      init_cycle    <= 1'b1;
    end else begin
      if (accept_start) begin
        force_active  <= force_pending | full_redraw;
        force_pending <= 1'b0;
      end else if (full_redraw) begin
        force_pending <= 1'b1;
      end
      if (state == S_DONE) begin
        force_active <= 1'b0;
        init_cycle   <= 1'b0;
      end
    end
  end

  // The frame buffer mirrors the screen, so it only changes when the engine confirms a draw.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < CELLS; i++) fb[i] <= '0;
    end else if (accept_done) begin
      fb[draw_idx] <= draw_code;
    end
  end

endmodule

// File: tb/tb_cell_draw_scheduler.sv
// Directed bench for cell_draw_scheduler: a scene table feeds obj_code_in from the
// scan coordinates and each pass's draw commands are checked against an expected list.
module tb_cell_draw_scheduler;

  logic       tb_clk = 1'b0;
  logic       nrst;
  logic       start;
  logic       full_redraw;
  logic       cmd_done;
  logic [2:0] obj_code_in;
  logic [3:0] x;
  logic [3:0] y;
  logic       draw_req;
  logic [3:0] draw_x;
  logic [3:0] draw_y;
  logic [2:0] draw_code;
  logic       busy;
  logic       frame_done;
  logic       init_cycle;
  logic [1:0] state_dbg;

  logic [2:0]  scene [256];
  logic [10:0] exp_q [$];
  logic [10:0] obs_q [$];

  int   checks = 0;
  int   errors = 0;
  int   last_fd_cyc;
  logic last_init_fd;
  logic last_busy_ok;

  cell_draw_scheduler #(.GRID_W(16), .GRID_H(12), .CODE_W(3)) dut (
    .clk         (tb_clk),
    .nrst        (nrst),
    .start       (start),
    .obj_code_in (obj_code_in),
    .full_redraw (full_redraw),
    .cmd_done    (cmd_done),
    .x           (x),
    .y           (y),
    .draw_req    (draw_req),
    .draw_x      (draw_x),
    .draw_y      (draw_y),
    .draw_code   (draw_code),
    .busy        (busy),
    .frame_done  (frame_done),
    .init_cycle  (init_cycle),
    .state_dbg   (state_dbg)
  );

  always #5 tb_clk = ~tb_clk;

  // Game logic stand-in: the row-major index is {y,x} because the grid is 16 wide.
  assign obj_code_in = scene[{y, x}];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic build_full();
    exp_q.delete();
    for (int yy = 0; yy < 12; yy++)
      for (int xx = 0; xx < 16; xx++)
        exp_q.push_back({4'(yy), 4'(xx), scene[yy * 16 + xx]});
  endtask

  task automatic compare_draws(input string tag);
    check({tag, "_count"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
      check(tag, 32'(obs_q[i]), 32'(exp_q[i]));
  endtask

  // One pass: start pulse, then acknowledge each draw after dly extra WAIT cycles.
  // fr_at / st_at inject a full_redraw / start pulse at that pass cycle (-1 = never).
  task automatic run_pass(input int dly, input int fr_at, input int st_at, input bit fr_with_start);
    int          cyc;
    bit          fd_seen;
    logic [10:0] rec;
    obs_q.delete();
    last_busy_ok = 1'b1;
    last_init_fd = 1'bx;
    last_fd_cyc  = -1;
    fd_seen      = 1'b0;
    start        = 1'b1;
    full_redraw  = fr_with_start;
    @(negedge tb_clk);
    start       = 1'b0;
    full_redraw = 1'b0;
    cyc         = 1;
    while (!fd_seen && cyc < 3000) begin
      start       = (cyc == st_at);
      full_redraw = (cyc == fr_at);
      if (frame_done) begin
        fd_seen      = 1'b1;
        last_fd_cyc  = cyc;
        last_init_fd = init_cycle;
      end else begin
        if (!busy) last_busy_ok = 1'b0;
        if (draw_req) begin
          rec = {draw_y, draw_x, draw_code};
          obs_q.push_back(rec);
          for (int k = 0; k < dly; k++) begin
            @(negedge tb_clk);
            start       = 1'b0;
            full_redraw = 1'b0;
            cyc++;
            check("wait_draw_req", draw_req, 1'b1);
            check("wait_frozen", {y, x, draw_y, draw_x}, {rec[10:3], rec[10:3]});
          end
          cmd_done = 1'b1;
          @(negedge tb_clk);
          cmd_done = 1'b0;
        end else begin
          @(negedge tb_clk);
        end
        start       = 1'b0;
        full_redraw = 1'b0;
        cyc++;
      end
    end
    start       = 1'b0;
    full_redraw = 1'b0;
    check("pass_done_seen", fd_seen, 1'b1);
    @(negedge tb_clk);
    check("frame_done_pulse", frame_done, 1'b0);
    check("idle_after_pass", busy, 1'b0);
  endtask

  initial begin
    int  wait_cnt;
    bit  req_seen;
    nrst        = 1'b0;
    start       = 1'b0;
    full_redraw = 1'b0;
    cmd_done    = 1'b0;
    for (int i = 0; i < 256; i++) scene[i] = 3'd0;
    for (int yy = 0; yy < 12; yy++)
      for (int xx = 0; xx < 16; xx++)
        if (xx == 0 || xx == 15 || yy == 0 || yy == 11) scene[yy * 16 + xx] = 3'd1;

    // Reset state
    #12;
    check("rst_xy", {y, x}, 8'h00);
    check("rst_draw", {draw_req, draw_y, draw_x, draw_code}, 12'h000);
    check("rst_busy", busy, 1'b0);
    check("rst_frame_done", frame_done, 1'b0);
    check("rst_init_cycle", init_cycle, 1'b1);
    check("rst_state", state_dbg, 2'd0);
    @(negedge tb_clk);
    nrst = 1'b1;
    @(negedge tb_clk);

    // 1: first pass redraws every cell in raster order
    build_full();
    run_pass(0, -1, -1, 1'b0);
    compare_draws("t1_draws");
    check("t1_fd_cycle", last_fd_cyc, 32'd385);
    check("t1_init_at_done", last_init_fd, 1'b1);
    check("t1_init_after", init_cycle, 1'b0);

    // 2: unchanged scene, no draws, 193-cycle pass
    exp_q.delete();
    run_pass(0, -1, -1, 1'b0);
    compare_draws("t2_draws");
    check("t2_fd_cycle", last_fd_cyc, 32'd193);
    check("t2_busy_span", last_busy_ok, 1'b1);

    // 3: two changed cells, then a clean repeat
    scene[4 * 16 + 4] = 3'd2;
    scene[4 * 16 + 7] = 3'd3;
    exp_q.delete();
    exp_q.push_back({4'd4, 4'd4, 3'd2});
    exp_q.push_back({4'd4, 4'd7, 3'd3});
    run_pass(0, -1, -1, 1'b0);
    compare_draws("t3_draws");
    check("t3_fd_cycle", last_fd_cyc, 32'd195);
    exp_q.delete();
    run_pass(0, -1, -1, 1'b0);
    compare_draws("t3_repeat");

    // 4: slow cmd_done with a stray start mid-pass, then cmd_done while idle
    scene[4 * 16 + 7] = 3'd4;
    exp_q.delete();
    exp_q.push_back({4'd4, 4'd7, 3'd4});
    run_pass(5, -1, 50, 1'b0);
    compare_draws("t4_slow_draw");
    check("t4_fd_cycle", last_fd_cyc, 32'd199);
    repeat (3) @(negedge tb_clk);
    check("t4_start_not_queued", busy, 1'b0);
    scene[2 * 16 + 2] = 3'd5;
    cmd_done = 1'b1;
    @(negedge tb_clk);
    cmd_done = 1'b0;
    check("t4_idle_cmd_done", busy, 1'b0);
    exp_q.delete();
    exp_q.push_back({4'd2, 4'd2, 3'd5});
    run_pass(0, -1, -1, 1'b0);
    compare_draws("t4_after_idle_done");

    // 5: full_redraw mid-pass defers, full_redraw with start applies now
    scene[9 * 16 + 9] = 3'd2;
    exp_q.delete();
    exp_q.push_back({4'd9, 4'd9, 3'd2});
    run_pass(0, 100, -1, 1'b0);
    compare_draws("t5_mid_pass");
    build_full();
    run_pass(0, -1, -1, 1'b0);
    compare_draws("t5_forced");
    build_full();
    run_pass(0, -1, -1, 1'b1);
    compare_draws("t5_coincident");
    exp_q.delete();
    run_pass(0, -1, -1, 1'b0);
    compare_draws("t5_clean");

    // 6: reset while waiting on the draw at (7,4)
    scene[4 * 16 + 7] = 3'd1;
    start = 1'b1;
    @(negedge tb_clk);
    start    = 1'b0;
    req_seen = 1'b0;
    wait_cnt = 0;
    while (!req_seen && wait_cnt < 400) begin
      if (draw_req) req_seen = 1'b1;
      else begin
        @(negedge tb_clk);
        wait_cnt++;
      end
    end
    check("t6_req_seen", req_seen, 1'b1);
    check("t6_draw_xy", {draw_y, draw_x}, {4'd4, 4'd7});
    nrst = 1'b0;
    #1;
    check("t6_rst_draw_req", draw_req, 1'b0);
    check("t6_rst_busy", busy, 1'b0);
    check("t6_rst_init", init_cycle, 1'b1);
    @(negedge tb_clk);
    nrst = 1'b1;
    @(negedge tb_clk);
    build_full();
    run_pass(0, -1, -1, 1'b0);
    compare_draws("t6_full_after_rst");
    check("t6_fd_cycle", last_fd_cyc, 32'd385);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
